// File: rtl/fetch_inst_queue.sv
// Instruction queue between fetch and pre-decode: multi-lane circular FIFO.
// Optional same-cycle bypass when empty, enabled by RSD_FETCH_QUEUE_BYPASS_EN.
module fetch_inst_queue #(
    parameter int FETCH_WIDTH  = 2,
    parameter int DECODE_WIDTH = 2,
    parameter int DEPTH        = 8,
    parameter int ENTRY_WIDTH  = 97
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 flush,
    input  logic [FETCH_WIDTH-1:0]               in_valid,
    input  logic [FETCH_WIDTH*ENTRY_WIDTH-1:0]   in_entry,
    output logic                                 in_stall,
    output logic [DECODE_WIDTH-1:0]              out_valid,
    output logic [DECODE_WIDTH*ENTRY_WIDTH-1:0]  out_entry,
    input  logic                                 out_stall,
    output logic [$clog2(DEPTH):0]               count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
`ifdef RSD_FETCH_QUEUE_BYPASS_EN
    localparam int BW = (FETCH_WIDTH < DECODE_WIDTH) ? FETCH_WIDTH : DECODE_WIDTH;
`endif

    logic [PW-1:0]          head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]          count_q, count_d;
    logic [ENTRY_WIDTH-1:0] mem_q [DEPTH];
    logic [ENTRY_WIDTH-1:0] mem_d [DEPTH];
    logic                   enq_ok;
    int                     in_cnt, skip, enq_cnt, deq_cnt;

    function automatic int popcnt(input logic [FETCH_WIDTH-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < FETCH_WIDTH; i++) n += int'(v[i]);
        return n;
    endfunction

    // Backpressure looks only at registered occupancy.
    assign in_stall = (DEPTH - int'(count_q)) < FETCH_WIDTH;
    assign count    = count_q;

    always_comb begin
        in_cnt    = popcnt(in_valid);
        skip      = 0;
        out_valid = '0;
        out_entry = '0;
        for (int i = 0; i < DECODE_WIDTH; i++) begin
            if (int'(count_q) > i) begin
                out_valid[i] = 1'b1;
                out_entry[i*ENTRY_WIDTH +: ENTRY_WIDTH] = mem_q[head_q + PW'(i)];
            end
        end
`ifdef RSD_FETCH_QUEUE_BYPASS_EN
        // Empty queue: leading input lanes go straight out and skip storage.
        if (count_q == '0 && rst && !flush && !out_stall) begin
            skip = (in_cnt < BW) ? in_cnt : BW;
            for (int i = 0; i < BW; i++) begin
                out_valid[i] = in_valid[i];
                out_entry[i*ENTRY_WIDTH +: ENTRY_WIDTH] =
                    in_valid[i] ? in_entry[i*ENTRY_WIDTH +: ENTRY_WIDTH] : '0;
            end
        end
`endif
        enq_ok  = !flush && !in_stall;
        enq_cnt = enq_ok ? (in_cnt - skip) : 0;
        deq_cnt = (flush || out_stall) ? 0 :
                  ((int'(count_q) < DECODE_WIDTH) ? int'(count_q) : DECODE_WIDTH);

        mem_d = mem_q;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (enq_ok && in_valid[i] && i >= skip)
                mem_d[tail_q + PW'(i - skip)] = in_entry[i*ENTRY_WIDTH +: ENTRY_WIDTH];
        end

        head_d  = head_q + PW'(deq_cnt);
        tail_d  = tail_q + PW'(enq_cnt);
        count_d = count_q + CW'(enq_cnt) - CW'(deq_cnt);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage needs no reset; unoccupied lanes are masked on read.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_fetch_inst_queue.sv
// Directed-vector bench for fetch_inst_queue (default build, no bypass).
module tb_fetch_inst_queue;

    localparam int EW = 97;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic [1:0]      in_valid;
    logic [2*EW-1:0] in_entry;
    logic            in_stall;
    logic [1:0]      out_valid;
    logic [2*EW-1:0] out_entry;
    logic            out_stall;
    logic [3:0]      count;

    int checks = 0;
    int errors = 0;

    fetch_inst_queue dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_entry(in_entry), .in_stall(in_stall),
        .out_valid(out_valid), .out_entry(out_entry), .out_stall(out_stall),
        .count(count)
    );

    always #5 clk = ~clk;

    // Distinct bits in every payload field so corruption of any field shows.
    function automatic logic [EW-1:0] mk(input logic [31:0] pc);
        return {pc[2], pc ^ 32'hdead0000, pc, ~pc};
    endfunction

    typedef struct {
        logic        r;
        logic        fl;
        logic [1:0]  iv;
        logic [31:0] p0, p1;
        logic        os;
        int          ec;
        logic        es;
        logic [1:0]  eov;
        logic [31:0] e0, e1;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(logic r, logic fl, logic [1:0] iv, logic [31:0] p0, logic [31:0] p1,
                               logic os, int ec, logic es, logic [1:0] eov,
                               logic [31:0] e0, logic [31:0] e1);
        vec_t t;
        t.r = r; t.fl = fl; t.iv = iv; t.p0 = p0; t.p1 = p1; t.os = os;
        t.ec = ec; t.es = es; t.eov = eov; t.e0 = e0; t.e1 = e1;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic fl, input logic [1:0] iv,
                         input logic [31:0] p0, input logic [31:0] p1, input logic os);
        rst = r; flush = fl; in_valid = iv; out_stall = os;
        in_entry = {mk(p1), mk(p0)};
    endtask

    logic [31:0] sb[$];
    logic [EW-1:0] exp_l0, exp_l1;
    int popped;

    initial begin
        drive(1'b0, 1'b0, 2'b00, 0, 0, 1'b1);

        // r fl  iv     p0        p1        os  cnt stl ov     e0        e1
        tbl.push_back(v(0, 0, 2'b00, 0,        0,        1,  0, 0, 2'b00, 0,        0));
        tbl.push_back(v(1, 0, 2'b11, 'h1000, 'h1004, 1,  2, 0, 2'b11, 'h1000, 'h1004));
        tbl.push_back(v(1, 0, 2'b11, 'h1008, 'h100c, 1,  4, 0, 2'b11, 'h1000, 'h1004));
        tbl.push_back(v(1, 0, 2'b11, 'h1010, 'h1014, 1,  6, 0, 2'b11, 'h1000, 'h1004));
        tbl.push_back(v(1, 0, 2'b11, 'h1018, 'h101c, 1,  8, 1, 2'b11, 'h1000, 'h1004));
        tbl.push_back(v(1, 0, 2'b11, 'h1020, 'h1024, 1,  8, 1, 2'b11, 'h1000, 'h1004));
        // full, drain while fetch still offering: input ignored
        tbl.push_back(v(1, 0, 2'b11, 'h1020, 'h1024, 0,  6, 0, 2'b11, 'h1008, 'h100c));
        tbl.push_back(v(1, 0, 2'b00, 0,        0,        0,  4, 0, 2'b11, 'h1010, 'h1014));
        tbl.push_back(v(1, 0, 2'b01, 'h1020, 0,        1,  5, 0, 2'b11, 'h1010, 'h1014));
        // flush at count 5 drops same-cycle input
        tbl.push_back(v(1, 1, 2'b11, 'h1030, 'h1034, 0,  0, 0, 2'b00, 0,        0));
        // walk tail to 7, then enqueue across the wrap
        tbl.push_back(v(1, 0, 2'b11, 'h2000, 'h2004, 1,  2, 0, 2'b11, 'h2000, 'h2004));
        tbl.push_back(v(1, 0, 2'b11, 'h2008, 'h200c, 0,  2, 0, 2'b11, 'h2008, 'h200c));
        tbl.push_back(v(1, 0, 2'b11, 'h2010, 'h2014, 0,  2, 0, 2'b11, 'h2010, 'h2014));
        tbl.push_back(v(1, 0, 2'b01, 'h2018, 0,        0,  1, 0, 2'b01, 'h2018, 0));
        tbl.push_back(v(1, 0, 2'b11, 'h2020, 'h2024, 1,  3, 0, 2'b11, 'h2018, 'h2020));
        tbl.push_back(v(1, 0, 2'b00, 0,        0,        0,  1, 0, 2'b01, 'h2024, 0));
        tbl.push_back(v(1, 0, 2'b00, 0,        0,        0,  0, 0, 2'b00, 0,        0));
        // single lane, one-cycle latency
        tbl.push_back(v(1, 0, 2'b01, 'h3000, 0,        0,  1, 0, 2'b01, 'h3000, 0));
        tbl.push_back(v(1, 0, 2'b11, 'h3004, 'h3008, 1,  3, 0, 2'b11, 'h3000, 'h3004));
        tbl.push_back(v(1, 0, 2'b01, 'h300c, 0,        1,  4, 0, 2'b11, 'h3000, 'h3004));
        // reset mid-operation during an enqueue
        tbl.push_back(v(0, 0, 2'b11, 'h3010, 'h3014, 1,  0, 0, 2'b00, 0,        0));
        tbl.push_back(v(1, 0, 2'b11, 'h4000, 'h4004, 1,  2, 0, 2'b11, 'h4000, 'h4004));

        foreach (tbl[k]) begin
            @(negedge clk);
            drive(tbl[k].r, tbl[k].fl, tbl[k].iv, tbl[k].p0, tbl[k].p1, tbl[k].os);
            @(posedge clk);
            #1;
            exp_l0 = tbl[k].eov[0] ? mk(tbl[k].e0) : '0;
            exp_l1 = tbl[k].eov[1] ? mk(tbl[k].e1) : '0;
            chk($sformatf("v%0d count", k), 256'(count), 256'(tbl[k].ec));
            chk($sformatf("v%0d in_stall", k), 256'(in_stall), 256'(tbl[k].es));
            chk($sformatf("v%0d out_valid", k), 256'(out_valid), 256'(tbl[k].eov));
            chk($sformatf("v%0d out_entry", k), 256'(out_entry), 256'({exp_l1, exp_l0}));
        end

        // Stack three more behind 4000/4004, then drain against an in-order model.
        sb = '{32'h4000, 32'h4004};
        @(negedge clk); drive(1'b1, 1'b0, 2'b01, 'h4008, 0, 1'b1); sb.push_back(32'h4008);
        @(negedge clk); drive(1'b1, 1'b0, 2'b11, 'h400c, 'h4010, 1'b1);
        sb.push_back(32'h400c); sb.push_back(32'h4010);
        @(negedge clk); drive(1'b1, 1'b0, 2'b00, 0, 0, 1'b0);
        for (int cyc = 0; cyc < 10 && sb.size() > 0; cyc++) begin
            #1;
            popped = (sb.size() < 2) ? sb.size() : 2;
            chk($sformatf("drain%0d count", cyc), 256'(count), 256'(sb.size()));
            chk($sformatf("drain%0d out_valid", cyc), 256'(out_valid),
                256'((popped == 2) ? 2'b11 : 2'b01));
            for (int l = 0; l < popped; l++)
                chk($sformatf("drain%0d lane%0d", cyc, l),
                    256'(out_entry[l*EW +: EW]), 256'(mk(sb[l])));
            @(posedge clk);
            for (int l = 0; l < popped; l++) void'(sb.pop_front());
            @(negedge clk);
        end
        chk("drain_done", 256'(sb.size()), 256'(0));
        #1;
        chk("drain_empty_count", 256'(count), 256'(0));
        chk("drain_empty_valid", 256'(out_valid), 256'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
